// File: rtl/key_event_scheduler.sv
// -----------------------------------------------------------------------------
// key_event_scheduler
//   Debounces NUM_KEYS push-buttons against one shared tick. Each key gets a
//   two-state debounce FSM. A key must stay at its new raw level for DEB_MS
//   ticks before its debounced level changes. A key held for LONG_MS ticks
//   raises a long-press event. PRESS / LONG / RELEASE events from all keys are
//   queued as per-key pending flags. A fixed-priority arbiter moves them onto
//   a single valid/ready event port.
//
// Ports
//   clk_100M   in   system clock, all logic on the rising edge
//   rst        in   synchronous, active-high reset
//   key_in     in   raw asynchronous buttons, 1 = pressed
//   key_level  out  debounced key levels
//   evt_valid  out  event register holds an event
//   evt_ready  in   consumer takes the event when evt_valid & evt_ready
//   evt_key    out  key index of the current event
//   evt_type   out  01 PRESS, 10 LONG, 11 RELEASE
//   overflow   out  sticky flag: an event was dropped
//   ovf_clr    in   one-cycle pulse clears overflow
// -----------------------------------------------------------------------------
module key_event_scheduler #(
   parameter int NUM_KEYS = 5,
   parameter int KEY_W    = 3,
   parameter int TICK_DIV = 100000,
   parameter int DEB_MS   = 20,
   parameter int LONG_MS  = 1000
) (
   input  logic                clk_100M,
   input  logic                rst,
   input  logic [NUM_KEYS-1:0] key_in,
   output logic [NUM_KEYS-1:0] key_level,
   output logic                evt_valid,
   input  logic                evt_ready,
   output logic [KEY_W-1:0]    evt_key,
   output logic [1:0]          evt_type,
   output logic                overflow,
   input  logic                ovf_clr
);

   localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int DEB_W  = $clog2(DEB_MS + 1);
   localparam int HOLD_W = $clog2(LONG_MS + 1);

   localparam logic [1:0] EVT_PRESS = 2'b01;
   localparam logic [1:0] EVT_LONG  = 2'b10;
   localparam logic [1:0] EVT_REL   = 2'b11;

   typedef enum logic {ST_IDLE = 1'b0, ST_CHECK = 1'b1} deb_state_t;

   logic [NUM_KEYS-1:0] sync0, sync1;
   logic [TICK_W-1:0]   tick_cnt;
   logic                tick;

   deb_state_t          state    [NUM_KEYS];
   logic [DEB_W-1:0]    deb_cnt  [NUM_KEYS];
   logic [HOLD_W-1:0]   hold_cnt [NUM_KEYS];

   logic [NUM_KEYS-1:0] pend_press, pend_long, pend_rel;
   logic [NUM_KEYS-1:0] accept, set_press, set_long, set_rel;
   logic [NUM_KEYS-1:0] clr_press, clr_long, clr_rel;

   logic                load;
   logic                sel_found;
   int                  sel_idx;
   logic [1:0]          sel_type;
   logic                ovf_set;

   assign tick = (tick_cnt == TICK_W'(TICK_DIV - 1));

   // Event sources. A level change is accepted on the tick that brings
   // deb_cnt up to DEB_MS. LONG fires on the tick that brings hold_cnt up to
   // LONG_MS. After that, hold_cnt saturates, so LONG fires once per press.
   // NOTE: every signal written here gets a default first, so no latch can form.
   always_comb begin
      accept    = '0;
      set_press = '0;
      set_long  = '0;
      set_rel   = '0;
      for (int k = 0; k < NUM_KEYS; k++) begin
         accept[k]    = (state[k] == ST_CHECK) && (sync1[k] != key_level[k]) &&
                        tick && (deb_cnt[k] == DEB_W'(DEB_MS - 1));
         set_press[k] = accept[k] &  sync1[k];
         set_rel[k]   = accept[k] & ~sync1[k];
         set_long[k]  = key_level[k] & tick & (hold_cnt[k] == HOLD_W'(LONG_MS - 1));
      end
   end

   // Arbiter: the lowest key index wins. Within a key, PRESS > LONG > RELEASE.
   // The loop runs downwards so the last hit is the lowest index.
   always_comb begin
      load      = ~evt_valid | evt_ready;
      sel_found = 1'b0;
      sel_idx   = 0;
      sel_type  = 2'b00;
      clr_press = '0;
      clr_long  = '0;
      clr_rel   = '0;
      for (int k = NUM_KEYS - 1; k >= 0; k--) begin
         if (pend_press[k] | pend_long[k] | pend_rel[k]) begin
            sel_found = 1'b1;
            sel_idx   = k;
            sel_type  = pend_press[k] ? EVT_PRESS : (pend_long[k] ? EVT_LONG : EVT_REL);
         end
      end
      for (int k = 0; k < NUM_KEYS; k++) begin
         clr_press[k] = load && sel_found && (sel_idx == k) && (sel_type == EVT_PRESS);
         clr_long[k]  = load && sel_found && (sel_idx == k) && (sel_type == EVT_LONG);
         clr_rel[k]   = load && sel_found && (sel_idx == k) && (sel_type == EVT_REL);
      end
      // A new event overflows only if its flag stays set this cycle. If the
      // same flag is being handed to the output register, the new event
      // re-arms the flag and nothing is lost.
      ovf_set = |((set_press & pend_press & ~clr_press) |
                  (set_long  & pend_long  & ~clr_long)  |
                  (set_rel   & pend_rel   & ~clr_rel));
   end

   // NOTE: sequential state uses non-blocking assignments only, so every flop
   // here sees the values from before this edge.
   always_ff @(posedge clk_100M) begin
      if (rst) begin
         sync0      <= '0;
         sync1      <= '0;
         tick_cnt   <= '0;
         key_level  <= '0;
         pend_press <= '0;
         pend_long  <= '0;
         pend_rel   <= '0;
         overflow   <= 1'b0;
         evt_valid  <= 1'b0;
         evt_key    <= '0;
         evt_type   <= 2'b00;
         // NOTE: these per-key arrays are ordinary control flops, not storage
         // RAM. A mid-run reset must return them to a known state, so they
         // are cleared here.
         for (int k = 0; k < NUM_KEYS; k++) begin
            state[k]    <= ST_IDLE;
            deb_cnt[k]  <= '0;
            hold_cnt[k] <= '0;
         end
      end else begin
         sync0    <= key_in;
         sync1    <= sync0;
         tick_cnt <= tick ? '0 : tick_cnt + 1'b1;

         for (int k = 0; k < NUM_KEYS; k++) begin
            if (state[k] == ST_IDLE) begin
               deb_cnt[k] <= '0;
               if (sync1[k] != key_level[k]) state[k] <= ST_CHECK;
            end else begin
               if (sync1[k] == key_level[k]) begin
                  state[k]   <= ST_IDLE;
                  deb_cnt[k] <= '0;
               end else if (accept[k]) begin
                  key_level[k] <= sync1[k];
                  state[k]     <= ST_IDLE;
                  deb_cnt[k]   <= '0;
               end else if (tick) begin
                  deb_cnt[k] <= deb_cnt[k] + 1'b1;
               end
            end

            if (!key_level[k])
               hold_cnt[k] <= '0;
            else if (tick && (hold_cnt[k] != HOLD_W'(LONG_MS)))
               hold_cnt[k] <= hold_cnt[k] + 1'b1;
         end

         pend_press <= (pend_press & ~clr_press) | set_press;
         pend_long  <= (pend_long  & ~clr_long)  | set_long;
         pend_rel   <= (pend_rel   & ~clr_rel)   | set_rel;

         if (ovf_set)
            overflow <= 1'b1;
         else if (ovf_clr)
            overflow <= 1'b0;

         if (load) begin
            evt_valid <= sel_found;
            if (sel_found) begin
               evt_key  <= KEY_W'(sel_idx);
               evt_type <= sel_type;
            end
         end
      end
   end

endmodule
